// File: rtl/sram_march_bist_if.sv
// SRAM bus between the March BIST controller and a single-port SRAM.
// master: drives o_csn/o_wen/o_wr_data/o_addr, receives i_rd_data.
interface sram_march_bist_if #(
    parameter int DW = 10,
    parameter int AW = 8
);
    logic          o_csn;
    logic          o_wen;
    logic [DW-1:0] o_wr_data;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] i_rd_data;

    modport master (
        output o_csn, o_wen, o_wr_data, o_addr,
        input  i_rd_data
    );

    modport slave (
        input  o_csn, o_wen, o_wr_data, o_addr,
        output i_rd_data
    );
endinterface

// File: rtl/sram_march_bist.sv
// March C- BIST controller for a single-port synchronous SRAM.
// Ports: i_clock, i_reset, i_bist_en, i_mode, bus (SRAM master),
//        o_busy, o_b_done, o_b_err, o_fail_addr, o_fail_cnt.
module sram_march_bist #(
    parameter int DW     = 10,
    parameter int AW     = 8,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_bist_en,
    input  logic               i_mode,
    sram_march_bist_if.master  bus,
    output logic               o_busy,
    output logic               o_b_done,
    output logic               o_b_err,
    output logic [AW-1:0]      o_fail_addr,
    output logic [CNT_W-1:0]   o_fail_cnt
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD, S_WAIT, S_CMPW, S_CMP, S_DONE
    } state_t;

    localparam logic [AW-1:0]    A_MAX  = '1;
    localparam logic [AW-1:0]    A_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_MAX  = '1;
    localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    // WAIT lasts RD_LAT-1 cycles; counter counts down to zero
    localparam logic [1:0]       W_INIT = 2'(RD_LAT > 1 ? RD_LAT - 2 : 0);

    state_t           r_state;
    logic [2:0]       r_elem;
    logic             r_mode;
    logic [1:0]       r_wait;
    logic             r_csn;
    logic             r_wen;
    logic [DW-1:0]    r_wr_data;
    logic [AW-1:0]    r_addr;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [AW-1:0]    r_fail_addr;
    logic [CNT_W-1:0] r_fail_cnt;

    function automatic logic [DW-1:0] bg(input logic [AW-1:0] a,
                                         input logic m);
        logic [DW-1:0] p;
        for (int i = 0; i < DW; i++) p[i] = ((i % 2) == 1);
        if (!m) return '0;
        return a[0] ? ~p : p;
    endfunction

    logic          w_down;
    logic          w_last;
    logic          w_rinv;
    logic          w_winv;
    logic          w_go_cmp;
    logic          w_miss;
    logic [2:0]    w_nx_elem;
    logic [AW-1:0] w_nx_addr;
    logic [DW-1:0] w_exp;
    logic [DW-1:0] w_wval;

    always_comb begin
        w_down    = (r_elem == 3'd3) || (r_elem == 3'd4);
        w_last    = w_down ? (r_addr == '0) : (r_addr == A_MAX);
        w_rinv    = (r_elem == 3'd2) || (r_elem == 3'd4);
        w_winv    = (r_elem == 3'd1) || (r_elem == 3'd3);
        w_nx_elem = w_last ? r_elem + 3'd1 : r_elem;
        w_nx_addr = w_down ? r_addr - A_ONE : r_addr + A_ONE;
        // down elements start at the top, up elements at zero
        if (w_last)
            w_nx_addr = (w_nx_elem == 3'd3 || w_nx_elem == 3'd4) ? A_MAX : '0;
        w_exp     = bg(r_addr, r_mode) ^ {DW{w_rinv}};
        w_wval    = bg(r_addr, r_mode) ^ {DW{w_winv}};
        w_miss    = (bus.i_rd_data != w_exp);
        w_go_cmp  = (r_state == S_RD && RD_LAT == 1) ||
                    (r_state == S_WAIT && r_wait == 2'd0);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_elem      <= 3'd0;
            r_mode      <= 1'b0;
            r_wait      <= 2'd0;
            r_csn       <= 1'b1;
            r_wen       <= 1'b1;
            r_wr_data   <= '0;
            r_addr      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_fail_addr <= '0;
            r_fail_cnt  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: if (i_bist_en) begin
                    r_state     <= S_WR;
                    r_elem      <= 3'd0;
                    r_addr      <= '0;
                    r_mode      <= i_mode;
                    r_csn       <= 1'b0;
                    r_wen       <= 1'b0;
                    r_wr_data   <= bg('0, i_mode);
                    r_busy      <= 1'b1;
                    r_done      <= 1'b0;
                    r_err       <= 1'b0;
                    r_fail_addr <= '0;
                    r_fail_cnt  <= '0;
                end
                S_DONE: if (!i_bist_en) begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: if (!i_bist_en) begin
                    // abort: any in-flight compare is dropped
                    r_state <= S_IDLE;
                    r_csn   <= 1'b1;
                    r_wen   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end else if (r_state == S_RD || r_state == S_WAIT) begin
                    if (w_go_cmp) begin
                        if (r_elem == 3'd5) begin
                            r_state <= S_CMP;
                            r_csn   <= 1'b1;
                            r_wen   <= 1'b1;
                        end else begin
                            r_state   <= S_CMPW;
                            r_csn     <= 1'b0;
                            r_wen     <= 1'b0;
                            r_wr_data <= w_wval;
                        end
                    end else if (r_state == S_RD) begin
                        r_state <= S_WAIT;
                        r_wait  <= W_INIT;
                        r_csn   <= 1'b1;
                        r_wen   <= 1'b1;
                    end else begin
                        r_wait <= r_wait - 2'd1;
                    end
                end else begin
                    if (r_state != S_WR && w_miss) begin
                        r_err <= 1'b1;
                        if (r_fail_cnt == '0) r_fail_addr <= r_addr;
                        if (r_fail_cnt != C_MAX) r_fail_cnt <= r_fail_cnt + C_ONE;
                    end
                    if (w_last && r_elem == 3'd5) begin
                        r_state <= S_DONE;
                        r_csn   <= 1'b1;
                        r_wen   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_elem <= w_nx_elem;
                        r_addr <= w_nx_addr;
                        r_csn  <= 1'b0;
                        if (w_nx_elem == 3'd0) begin
                            r_state   <= S_WR;
                            r_wen     <= 1'b0;
                            r_wr_data <= bg(w_nx_addr, r_mode);
                        end else begin
                            r_state <= S_RD;
                            r_wen   <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.o_csn     = r_csn;
    assign bus.o_wen     = r_wen;
    assign bus.o_wr_data = r_wr_data;
    assign bus.o_addr    = r_addr;
    assign o_busy        = r_busy;
    assign o_b_done      = r_done;
    assign o_b_err       = r_err;
    assign o_fail_addr   = r_fail_addr;
    assign o_fail_cnt    = r_fail_cnt;
endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: three instances (lat 1, lat 3, 2-bit counter)
// with SRAM models; results and bus accesses checked via scoreboards.
module tb_sram_march_bist;
    typedef struct {
        int id;
        int cyc;
        int err;
        int faddr;
        int fcnt;
    } res_t;

    typedef struct {
        int wen;
        int addr;
        int data;
    } acc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic en0 = 1'b0;
    logic en1 = 1'b0;
    logic en2 = 1'b0;
    logic mode0 = 1'b0;
    logic stuck5 = 1'b0;
    logic lat3 = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    res_t res_q[$];
    acc_t acc_q[$];

    sram_march_bist_if #(.DW(10), .AW(4)) bus0();
    sram_march_bist_if #(.DW(10), .AW(4)) bus1();
    sram_march_bist_if #(.DW(10), .AW(4)) bus2();

    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic       err0, err1, err2;
    logic [3:0] fa0, fa1, fa2;
    logic [7:0] fc0, fc1;
    logic [1:0] fc2;

    sram_march_bist #(.DW(10), .AW(4), .RD_LAT(1), .CNT_W(8)) u0 (
        .i_clock(clk), .i_reset(rst), .i_bist_en(en0), .i_mode(mode0),
        .bus(bus0), .o_busy(busy0), .o_b_done(done0), .o_b_err(err0),
        .o_fail_addr(fa0), .o_fail_cnt(fc0)
    );
    sram_march_bist #(.DW(10), .AW(4), .RD_LAT(3), .CNT_W(8)) u1 (
        .i_clock(clk), .i_reset(rst), .i_bist_en(en1), .i_mode(1'b0),
        .bus(bus1), .o_busy(busy1), .o_b_done(done1), .o_b_err(err1),
        .o_fail_addr(fa1), .o_fail_cnt(fc1)
    );
    sram_march_bist #(.DW(10), .AW(4), .RD_LAT(1), .CNT_W(2)) u2 (
        .i_clock(clk), .i_reset(rst), .i_bist_en(en2), .i_mode(1'b0),
        .bus(bus2), .o_busy(busy2), .o_b_done(done2), .o_b_err(err2),
        .o_fail_addr(fa2), .o_fail_cnt(fc2)
    );

    // SRAM models: read data present only in the cycle(s) it is valid
    logic [9:0] mem0 [16];
    logic [9:0] mem1 [16];
    logic [9:0] q0 = '0;
    logic [9:0] q1a = '0, q1b = '0, q1c = '0;
    logic [9:0] rd0;

    assign rd0 = mem0[bus0.o_addr] | {9'b0, stuck5 && bus0.o_addr == 4'd5};

    always @(posedge clk) begin
        if (!bus0.o_csn && !bus0.o_wen) mem0[bus0.o_addr] <= bus0.o_wr_data;
        q0 <= (!bus0.o_csn && bus0.o_wen) ? rd0 : '0;
        if (!bus1.o_csn && !bus1.o_wen) mem1[bus1.o_addr] <= bus1.o_wr_data;
        q1a <= (!bus1.o_csn && bus1.o_wen) ? mem1[bus1.o_addr] : '0;
        q1b <= q1a;
        q1c <= q1b;
    end

    assign bus0.i_rd_data = q0;
    assign bus1.i_rd_data = lat3 ? q1c : q1a;
    assign bus2.i_rd_data = '1;

    logic a_busy [3];
    logic a_done [3];
    logic a_csn  [3];
    int   a_err  [3];
    int   a_fa   [3];
    int   a_fc   [3];

    assign a_busy[0] = busy0;
    assign a_busy[1] = busy1;
    assign a_busy[2] = busy2;
    assign a_done[0] = done0;
    assign a_done[1] = done1;
    assign a_done[2] = done2;
    assign a_csn[0]  = bus0.o_csn;
    assign a_csn[1]  = bus1.o_csn;
    assign a_csn[2]  = bus2.o_csn;
    assign a_err[0]  = 32'(err0);
    assign a_err[1]  = 32'(err1);
    assign a_err[2]  = 32'(err2);
    assign a_fa[0]   = 32'(fa0);
    assign a_fa[1]   = 32'(fa1);
    assign a_fa[2]   = 32'(fa2);
    assign a_fc[0]   = 32'(fc0);
    assign a_fc[1]   = 32'(fc1);
    assign a_fc[2]   = 32'(fc2);

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // result monitor: pops an expectation on each rising o_b_done
    initial begin
        logic pdone [3];
        logic seen  [3];
        int   t0    [3];
        res_t r;
        for (int i = 0; i < 3; i++) begin
            pdone[i] = 1'b0;
            seen[i]  = 1'b0;
            t0[i]    = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (a_busy[i] && !a_csn[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    t0[i]   = cyc;
                end
                if (a_done[i] && !pdone[i]) begin
                    if (res_q.size() == 0) begin
                        chk("unexpected_done", i, -1);
                    end else begin
                        r = res_q.pop_front();
                        chk("done_dut", i, r.id);
                        chk("run_cycles", cyc - t0[i], r.cyc);
                        chk("err", a_err[i], r.err);
                        chk("fail_addr", a_fa[i], r.faddr);
                        chk("fail_cnt", a_fc[i], r.fcnt);
                    end
                end
                if (!a_busy[i]) seen[i] = 1'b0;
                pdone[i] = a_done[i];
            end
        end
    end

    // bus monitor on u0: compares leading accesses of a run
    initial begin
        acc_t a;
        forever begin
            @(negedge clk);
            if (!bus0.o_csn && acc_q.size() > 0) begin
                a = acc_q.pop_front();
                chk("acc_wen", 32'(bus0.o_wen), a.wen);
                chk("acc_addr", 32'(bus0.o_addr), a.addr);
                if (a.wen == 0) chk("acc_data", 32'(bus0.o_wr_data), a.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_res(input int id, input int c, input int e,
                            input int fa, input int fc);
        res_t r;
        r.id = id; r.cyc = c; r.err = e; r.faddr = fa; r.fcnt = fc;
        res_q.push_back(r);
    endtask

    task automatic push_acc(input int w, input int ad, input int d);
        acc_t a;
        a.wen = w; a.addr = ad; a.data = d;
        acc_q.push_back(a);
    endtask

    task automatic wait_done(input int i, input int budget);
        int k = 0;
        while (!a_done[i] && k < budget) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        #1;
        chk("done_timeout", 32'(a_done[i]), 1);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_csn"}, 32'(bus0.o_csn), 1);
        chk({nm, "_wen"}, 32'(bus0.o_wen), 1);
        chk({nm, "_wdata"}, 32'(bus0.o_wr_data), 0);
        chk({nm, "_addr"}, 32'(bus0.o_addr), 0);
        chk({nm, "_busy"}, 32'(busy0), 0);
        chk({nm, "_done"}, 32'(done0), 0);
        chk({nm, "_err"}, 32'(err0), 0);
        chk({nm, "_faddr"}, 32'(fa0), 0);
        chk({nm, "_fcnt"}, 32'(fc0), 0);
    endtask

    initial begin
        tick(3);
        chk_reset_state("rst");
        rst = 1'b0;
        tick(2);

        // fault-free, solid background
        for (int i = 0; i < 16; i++) push_acc(0, i, 0);
        push_acc(1, 0, 0);
        push_acc(0, 0, 'h3FF);
        push_res(0, 176, 0, 0, 0);
        en0 = 1'b1;
        wait_done(0, 400);
        chk("done_busy", 32'(busy0), 0);
        chk("done_csn", 32'(bus0.o_csn), 1);
        tick(5);
        chk("done_held", 32'(done0), 1);
        en0 = 1'b0;
        tick(2);
        chk("idle_done", 32'(done0), 0);
        chk("acc_drained", acc_q.size(), 0);

        // stuck-at-1 bit0 at address 5
        stuck5 = 1'b1;
        push_res(0, 176, 1, 5, 3);
        en0 = 1'b1;
        wait_done(0, 400);
        en0 = 1'b0;
        tick(2);
        chk("keep_err", 32'(err0), 1);
        chk("keep_faddr", 32'(fa0), 5);
        chk("keep_fcnt", 32'(fc0), 3);

        // checkerboard; mode change mid-run must be ignored
        stuck5 = 1'b0;
        mode0 = 1'b1;
        for (int i = 0; i < 16; i++) push_acc(0, i, (i % 2) ? 'h155 : 'h2AA);
        push_acc(1, 0, 0);
        push_acc(0, 0, 'h155);
        push_res(0, 176, 0, 0, 0);
        en0 = 1'b1;
        tick(3);
        mode0 = 1'b0;
        wait_done(0, 400);
        en0 = 1'b0;
        tick(2);
        chk("cb_acc_drained", acc_q.size(), 0);

        // abort in M2, then restart
        stuck5 = 1'b1;
        en0 = 1'b1;
        tick(60);
        en0 = 1'b0;
        tick(1);
        chk("abort_csn", 32'(bus0.o_csn), 1);
        chk("abort_busy", 32'(busy0), 0);
        chk("abort_done", 32'(done0), 0);
        chk("abort_err", 32'(err0), 1);
        chk("abort_fcnt", 32'(fc0), 1);
        chk("abort_faddr", 32'(fa0), 5);
        tick(2);
        push_res(0, 176, 1, 5, 3);
        en0 = 1'b1;
        tick(1);
        chk("restart_busy", 32'(busy0), 1);
        chk("restart_err", 32'(err0), 0);
        chk("restart_fcnt", 32'(fc0), 0);
        wait_done(0, 400);
        en0 = 1'b0;
        tick(2);

        // asynchronous reset mid-run
        en0 = 1'b1;
        tick(40);
        chk("pre_rst_err", 32'(err0), 1);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_state("async");
        en0 = 1'b0;
        tick(1);
        rst = 1'b0;
        stuck5 = 1'b0;
        tick(2);

        // read latency 3, matched then mismatched model
        push_res(1, 336, 0, 0, 0);
        en1 = 1'b1;
        wait_done(1, 800);
        en1 = 1'b0;
        tick(2);
        lat3 = 1'b0;
        push_res(1, 336, 1, 0, 32);
        en1 = 1'b1;
        wait_done(1, 800);
        en1 = 1'b0;
        tick(2);

        // saturating 2-bit counter, all bits stuck at 1
        push_res(2, 176, 1, 0, 3);
        en2 = 1'b1;
        wait_done(2, 400);
        en2 = 1'b0;
        tick(2);

        chk("res_drained", res_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sram_march_bist.md
Name: sram_march_bist

Overview:
- Parametrised March C- BIST controller; successor to sram_bist.
- Drives a single-port synchronous SRAM through one address/data/control bus and compares read data against expected values.
- Reports done, a sticky error flag, the first failing address and a saturating fail count.
- Adds configurable data/address width, configurable SRAM read latency, and a solid or checkerboard data-background mode.

Parameters:
- DW, 10, data width in bits.
- AW, 8, address width in bits; depth is D = 2^AW and every address is tested.
- RD_LAT, 1, SRAM read latency in cycles; legal range 1..4.
- CNT_W, 8, fail-counter width in bits.

Ports:
- i_clock  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_bist_en  in  1  level run request.
- i_mode  in  1  0 = solid background, 1 = checkerboard; sampled only at start.
- i_rd_data  in  DW  SRAM read data, valid RD_LAT cycles after the read cycle.
- o_csn  out  1  SRAM chip select, active low.
- o_wen  out  1  SRAM write enable, active low; 1 = read.
- o_wr_data  out  DW  SRAM write data.
- o_addr  out  AW  SRAM address.
- o_busy  out  1  test in progress.
- o_b_done  out  1  test finished.
- o_b_err  out  1  sticky; at least one miscompare.
- o_fail_addr  out  AW  address of the first miscompare.
- o_fail_cnt  out  CNT_W  number of miscompares, saturating.

Behaviour:
- Reset values: o_csn=1, o_wen=1, o_wr_data=0, o_addr=0, o_busy=0, o_b_done=0, o_b_err=0, o_fail_addr=0, o_fail_cnt=0; state = IDLE.
- All outputs are registered.
- Background B(a):
  - mode 0: B(a) = all zeros.
  - mode 1: P = alternating bits with bit0=0 (10'h2AA for DW=10); B(a) = P if a[0]=0, else ~P.
  - "w0/r0" uses B(a); "w1/r1" uses ~B(a).
- Element sequence:
  - M0: up, w0.
  - M1: up, r0 then w1.
  - M2: up, r1 then w0.
  - M3: down, r0 then w1.
  - M4: down, r1 then w0.
  - M5: up, r0.
  - "up" runs 0..D-1; "down" runs D-1..0.
- States: IDLE, WR, RD, WAIT, CMPW, CMP, DONE.
- IDLE -> start:
  - Triggered when i_bist_en=1.
  - Clears err, fail_addr and fail_cnt; latches i_mode; o_busy=1.
  - Enters M0 at address 0.
- M0: WR state, one cycle per address (csn=0, wen=0).
- Read-modify elements (M1-M4), per address:
  - RD for one cycle (csn=0, wen=1).
  - WAIT for RD_LAT-1 cycles (csn=1).
  - CMPW for one cycle: writes the new value to the same address and compares i_rd_data against the expected value in that same cycle.
  - Cost: 1+RD_LAT cycles per address.
- M5: RD, WAIT, then CMP (csn=1, compare only); 1+RD_LAT cycles per address.
- Total run length: D + 5·D·(1+RD_LAT) cycles from the first SRAM access to o_b_done=1.
- Miscompare handling:
  - o_b_err is set.
  - o_fail_cnt increments, saturating at 2^CNT_W-1.
  - o_fail_addr is captured only when fail_cnt was 0 before the increment.
  - The test never stops early.
- Element boundary: the address wraps at 0 or D-1 and the next element starts in the next cycle; no idle cycles between elements.
- DONE:
  - o_b_done=1, o_busy=0, csn=1.
  - Held while i_bist_en=1.
  - i_bist_en=0 -> IDLE with o_b_done=0; err, fail_addr and fail_cnt are retained until the next start.
- Abort: i_bist_en=0 while busy -> IDLE next cycle.
  - csn=1, busy=0, done=0.
  - Results are retained as partial results.
  - Any in-flight compare is dropped.
- i_reset asserted mid-run: every output and state returns to its reset value immediately (asynchronous).
- i_mode changes mid-run are ignored.

Test Plan:
- Fault-free run, AW=4, DW=10, RD_LAT=1, mode 0, good SRAM model: raise i_bist_en -> o_b_done rises exactly 176 cycles after the first csn=0 cycle; err=0, fail_cnt=0. M0 writes 0 to addresses 0..15; M1 first access is a read of address 0, then a write of 10'h3FF.
- Stuck-at-1 on bit0 of address 5, mode 0 -> fails only on the r0 reads of M1, M3 and M5: err=1, fail_addr=5, fail_cnt=3.
- Checkerboard, mode 1, good SRAM -> M0 writes 10'h2AA to address 0 and 10'h155 to address 1; M1 writes 10'h155 to address 0; err=0 at done.
- RD_LAT=3, AW=4, good SRAM model with 3-cycle latency -> done after 16+5·16·4 = 336 cycles, err=0. Repeat with the model's latency mismatched to 1 -> err=1.
- Saturation: CNT_W=2, all-bits stuck-at-1 SRAM -> fail_cnt=3 and held, fail_addr=0.
- Abort and restart:
  - Drop i_bist_en in M2 -> csn=1 next cycle, busy=0, done=0, results retained.
  - Re-raise i_bist_en -> results cleared and a full-length run completes.
  - Assert i_reset mid-run -> all outputs return to 0 (csn and wen to 1) without waiting for a clock edge.
